// File: rtl/fifo_blockram_ctrl.sv
// FIFO controller backed by an external dual-port blockram with one-cycle
// read latency; a two-entry prefetch buffer keeps the head ready every cycle.
`ifndef BYTE_LEN_IN_BITS
`define BYTE_LEN_IN_BITS 8
`endif

module fifo_blockram_ctrl #(
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
    parameter int NUM_SET = 64,
    parameter int SET_PTR_WIDTH_IN_BITS = $clog2(NUM_SET),
    parameter int WRITE_MASK_LEN =
        SINGLE_ENTRY_WIDTH_IN_BITS / `BYTE_LEN_IN_BITS
) (
    input  logic                                  clk_in,
    input  logic                                  reset_in,

    input  logic                                  request_valid_in,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_data_in,
    output logic                                  request_ready_out,

    output logic                                  issue_valid_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] issue_data_out,
    input  logic                                  issue_ack_in,

    output logic                                  write_port_access_en_out,
    output logic [WRITE_MASK_LEN-1:0]             write_port_write_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]      write_port_access_set_addr_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] write_port_data_out,

    output logic                                  read_port_access_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]      read_port_access_set_addr_out,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] read_port_data_in,
    input  logic                                  read_port_valid_in,

    output logic [SET_PTR_WIDTH_IN_BITS:0]        count_out,
    output logic                                  full_out,
    output logic                                  empty_out,
    output logic                                  error_out
);

    localparam int DW = SINGLE_ENTRY_WIDTH_IN_BITS;
    localparam int AW = SET_PTR_WIDTH_IN_BITS;
    localparam int CW = SET_PTR_WIDTH_IN_BITS + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] ram_count;
    logic          rd_pending;
    logic [DW-1:0] buf0;
    logic [DW-1:0] buf1;
    logic [1:0]    buf_count;
    logic          error;

    logic          push;
    logic          pop;
    logic          rd_issue;
    logic [2:0]    occ;

    assign count_out = ram_count + CW'(rd_pending) + CW'(buf_count);
    assign full_out  = (count_out == CW'(NUM_SET));
    assign empty_out = (count_out == '0);

    assign request_ready_out = ~full_out & ~reset_in;
    assign push = request_valid_in & request_ready_out;
    assign pop  = issue_ack_in & issue_valid_out;

    // Buffer slots that will be claimed after this edge; pop frees one.
    assign occ = {1'b0, buf_count} + {2'b00, rd_pending} - {2'b00, pop};
    assign rd_issue = (ram_count != '0) & (occ < 3'd2);

    assign write_port_access_en_out       = push;
    assign write_port_write_en_out        = {WRITE_MASK_LEN{push}};
    assign write_port_access_set_addr_out = wr_ptr;
    assign write_port_data_out            = request_data_in;

    assign read_port_access_en_out       = rd_issue;
    assign read_port_access_set_addr_out = rd_ptr;

    assign issue_valid_out = (buf_count != 2'd0);
    assign issue_data_out  = buf0;
    assign error_out       = error;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_count  <= '0;
            rd_pending <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_issue)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, rd_issue})
                2'b10:   ram_count <= ram_count + CW'(1);
                2'b01:   ram_count <= ram_count - CW'(1);
                default: ram_count <= ram_count;
            endcase
            rd_pending <= rd_issue;
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            buf0      <= '0;
            buf1      <= '0;
            buf_count <= 2'd0;
            error     <= 1'b0;
        end else begin
            if (rd_pending && !read_port_valid_in)
                error <= 1'b1;
            if (rd_pending && pop) begin
                if (buf_count == 2'd2) begin
                    buf0 <= buf1;
                    buf1 <= read_port_data_in;
                end else begin
                    buf0 <= read_port_data_in;
                end
            end else if (rd_pending) begin
                if (buf_count == 2'd0)
                    buf0 <= read_port_data_in;
                else
                    buf1 <= read_port_data_in;
                buf_count <= buf_count + 2'd1;
            end else if (pop) begin
                buf0      <= buf1;
                buf_count <= buf_count - 2'd1;
            end
        end
    end

endmodule
